// File: rtl/aes_byte_loader_pkg.sv
// Shared definitions for the AES byte loader: block geometry, FSM state
// encoding and host command codes.
package aes_byte_loader_pkg;

  localparam int BLOCK_W     = 128;
  localparam int BLOCK_BYTES = BLOCK_W / 8;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RX_KEY   = 3'd1;
  localparam logic [2:0] ST_RX_STATE = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_TX       = 3'd4;

  // Host command bytes accepted in IDLE
  localparam logic [7:0] CMD_KEY   = 8'h01;
  localparam logic [7:0] CMD_STATE = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;

endpackage

// File: rtl/aes_byte_shifter.sv
// 128-bit byte-wide shift register with parallel load and parallel output.
// Shifting moves the block left by one byte and inserts shift_in at the LSB
// end, so the first byte shifted in finishes in the top byte after 16 shifts,
// and the top byte is always the next one to leave on the TX side.
module aes_byte_shifter
  import aes_byte_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift,
  input  logic [7:0]         shift_in,
  output logic [BLOCK_W-1:0] q
);

  // Parallel load has priority over a byte shift
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[BLOCK_W-9:0], shift_in};
    end
  end

endmodule

// File: rtl/aes_byte_loader.sv
// Byte-serial host front end for an AES-128 core. The host sends a command
// byte (key load, plaintext load, run) followed by any payload; the loader
// presents key/plaintext to the core, waits a fixed latency, captures the
// ciphertext and streams it back one byte at a time.
// Optional build macro: AES_BYTE_LOADER_CHK_EN appends a 17th byte holding
// the XOR of the 16 ciphertext bytes.
module aes_byte_loader
  import aes_byte_loader_pkg::*;
#(
  parameter int AES_LATENCY = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic [BLOCK_W-1:0] key_out,
  output logic [BLOCK_W-1:0] state_out,
  output logic               load_strobe,
  input  logic [BLOCK_W-1:0] ct_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               busy
);

  logic [2:0]         state;
  logic [3:0]         byte_cnt;
  logic [7:0]         wait_cnt;
  logic [4:0]         tx_cnt;
  logic               in_fire;
  logic               out_fire;
  logic               rx_shift_en;
  logic               rx_last;
  logic               wait_done;
  logic               tx_last;
  logic [BLOCK_W-1:0] rx_q;
  logic [BLOCK_W-1:0] tx_q;
  logic [BLOCK_W-1:0] rx_full;
  logic [7:0]         rx_unused_msb;

  assign in_ready    = (state == ST_IDLE) || (state == ST_RX_KEY) || (state == ST_RX_STATE);
  assign in_fire     = in_valid && in_ready;
  assign out_valid   = (state == ST_TX);
  assign out_fire    = out_valid && out_ready;
  assign busy        = (state != ST_IDLE);
  assign rx_shift_en = in_fire && ((state == ST_RX_KEY) || (state == ST_RX_STATE));
  assign rx_last     = rx_shift_en && (byte_cnt == 4'hF);
  assign wait_done   = (state == ST_WAIT) && (wait_cnt == 8'd1);

  // The 16th byte is merged combinationally so the commit happens on the
  // same edge that accepts it; the shadow's top byte is shifted out there.
  assign rx_full       = {rx_q[BLOCK_W-9:0], in_data};
  assign rx_unused_msb = rx_q[BLOCK_W-1:BLOCK_W-8];

`ifdef AES_BYTE_LOADER_CHK_EN
  logic [7:0] chk_acc;

  assign tx_last  = out_fire && (tx_cnt == 5'(BLOCK_BYTES));
  assign out_data = (tx_cnt == 5'(BLOCK_BYTES)) ? chk_acc : tx_q[BLOCK_W-1:BLOCK_W-8];

  // Running XOR of the ciphertext bytes as they leave; cleared at capture
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_acc <= '0;
    end else if (wait_done) begin
      chk_acc <= '0;
    end else if (out_fire && (tx_cnt < 5'(BLOCK_BYTES))) begin
      chk_acc <= chk_acc ^ tx_q[BLOCK_W-1:BLOCK_W-8];
    end
  end
`else
  assign tx_last  = out_fire && (tx_cnt == 5'(BLOCK_BYTES - 1));
  assign out_data = tx_q[BLOCK_W-1:BLOCK_W-8];
`endif

  // RX shadow: payload bytes enter from the LSB end
  aes_byte_shifter u_rx_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift     (rx_shift_en),
    .shift_in  (in_data),
    .q         (rx_q)
  );

  // TX shifter: ciphertext captured in parallel, top byte sent first
  aes_byte_shifter u_tx_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (wait_done),
    .load_data (ct_in),
    .shift     (out_fire),
    .shift_in  (8'h00),
    .q         (tx_q)
  );

  // Command decode, payload counting, latency wait and TX sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      wait_cnt <= '0;
      tx_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            case (in_data)
              CMD_KEY: begin
                state    <= ST_RX_KEY;
                byte_cnt <= '0;
              end
              CMD_STATE: begin
                state    <= ST_RX_STATE;
                byte_cnt <= '0;
              end
              CMD_RUN: begin
                state    <= ST_WAIT;
                wait_cnt <= 8'(AES_LATENCY);
              end
              default: ;
            endcase
          end
        end
        ST_RX_KEY, ST_RX_STATE: begin
          if (in_fire) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'hF) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 8'd1) begin
            state    <= ST_TX;
            wait_cnt <= '0;
            tx_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        ST_TX: begin
          if (out_fire) begin
            tx_cnt <= tx_cnt + 5'd1;
            if (tx_last) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Commit complete payloads to the core-facing registers and flag the update
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out     <= '0;
      state_out   <= '0;
      load_strobe <= 1'b0;
    end else begin
      load_strobe <= rx_last;
      if (rx_last && (state == ST_RX_KEY)) begin
        key_out <= rx_full;
      end
      if (rx_last && (state == ST_RX_STATE)) begin
        state_out <= rx_full;
      end
    end
  end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Scoreboard bench for aes_byte_loader. A behavioural AES core stand-in
// drives ct_in (FIPS-197 C.1 vector, otherwise a fixed mixing function) and
// only presents a valid result once key/state have been stable for the
// configured latency.
module tb_aes_byte_loader;

  localparam int L = 21;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [127:0] key_out;
  logic [127:0] state_out;
  logic         load_strobe;
  logic [127:0] ct_in;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt = 0;
  int strobe_snap;
  int n;
  logic [7:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] stall_byte = 8'h00;

  aes_byte_loader #(.AES_LATENCY(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .key_out     (key_out),
    .state_out   (state_out),
    .load_strobe (load_strobe),
    .ct_in       (ct_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // AES core stand-in
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] p);
    if (k == KEY_C1 && p == PT_C1) return CT_C1;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  logic [127:0] prev_key = '0;
  logic [127:0] prev_st  = '0;
  int           stable_cnt = 0;

  always @(posedge clk) begin
    prev_key <= key_out;
    prev_st  <= state_out;
    if (key_out != prev_key || state_out != prev_st) stable_cnt <= 0;
    else if (stable_cnt < 100000) stable_cnt <= stable_cnt + 1;
  end

  assign ct_in = (stable_cnt >= L - 1) ? core_f(key_out, state_out) : ~core_f(key_out, state_out);

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard pop on each transfer, hold check while stalled
  always @(negedge clk) begin
    if (load_strobe) strobe_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk_eq("tx_extra", 128'(out_valid), 128'(0));
      else chk_eq("tx_byte", 128'(out_data), 128'(exp_q.pop_front()));
    end
    if (out_valid && !out_ready) begin
      if (stall_prev) chk_eq("tx_stall_hold", 128'(out_data), 128'(stall_byte));
      stall_prev = 1'b1;
      stall_byte = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic put_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [7:0] cmd, input logic [127:0] v);
    put_byte(cmd);
    for (int i = 0; i < 16; i++) put_byte(v[127-8*i -: 8]);
    in_valid = 1'b0;
  endtask

  task automatic push_expect(input logic [127:0] v);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(v[127-8*i -: 8]);
      x = x ^ v[127-8*i -: 8];
    end
`ifdef AES_BYTE_LOADER_CHK_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_out_valid(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 1000) begin @(posedge clk); #1; k++; end
    if (k >= 1000) chk_eq(tag, 128'(out_valid), 128'(1));
  endtask

  task automatic wait_tx_done();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin @(posedge clk); #1; k++; end
    chk_eq("tx_drain", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_key",      key_out, 128'(0));
    chk_eq("rst_state",    state_out, 128'(0));
    chk_eq("rst_busy",     128'(busy), 128'(0));
    chk_eq("rst_out_vld",  128'(out_valid), 128'(0));
    chk_eq("rst_strobe",   128'(load_strobe), 128'(0));
    chk_eq("rst_out_data", 128'(out_data), 128'(0));
    chk_eq("rst_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: key load, with partial-load hold check
    put_byte(8'h01);
    for (int i = 0; i < 8; i++) put_byte(8'(i));
    chk_eq("key_partial_hold", key_out, 128'(0));
    chk_eq("busy_rx", 128'(busy), 128'(1));
    for (int i = 8; i < 16; i++) put_byte(8'(i));
    in_valid = 1'b0;
    chk_eq("key_commit", key_out, KEY_C1);
    chk_eq("strobe_high", 128'(load_strobe), 128'(1));
    @(posedge clk); #1;
    chk_eq("strobe_low", 128'(load_strobe), 128'(0));
    chk_eq("strobe_cnt_key", 128'(strobe_cnt), 128'(1));
    chk_eq("busy_after_key", 128'(busy), 128'(0));

    // Scenario 2: plaintext load and run; input held during WAIT is ignored
    send_block(8'h02, PT_C1);
    chk_eq("state_commit", state_out, PT_C1);
    @(posedge clk); #1;
    chk_eq("strobe_cnt_state", 128'(strobe_cnt), 128'(2));
    push_expect(CT_C1);
    put_byte(8'h03);
    in_valid = 1'b1; in_data = 8'h01;
    chk_eq("in_ready_wait", 128'(in_ready), 128'(0));
    n = 0;
    while (!out_valid && n < 1000) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    chk_eq("run_latency", 128'(n), 128'(L));
    chk_eq("in_ready_tx", 128'(in_ready), 128'(0));
    wait_tx_done();
    chk_eq("busy_after_tx", 128'(busy), 128'(0));
    chk_eq("key_untouched", key_out, KEY_C1);
    chk_eq("strobe_cnt_run", 128'(strobe_cnt), 128'(2));

    // Scenario 3: stall TX for 5 cycles mid-stream
    push_expect(CT_C1);
    put_byte(8'h03);
    in_valid = 1'b0;
    wait_out_valid("stall_tx_start");
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_tx_done();
    chk_eq("busy_after_stall", 128'(busy), 128'(0));

    // Scenario 4: reset during a partial plaintext load
    put_byte(8'h02);
    for (int i = 0; i < 7; i++) put_byte(8'hA0 + 8'(i));
    in_valid = 1'b0;
    strobe_snap = strobe_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_eq("abort_state_out", state_out, 128'(0));
    chk_eq("abort_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    chk_eq("abort_no_strobe", 128'(strobe_cnt), 128'(strobe_snap));

    // Scenario 5: unknown command dropped, next byte starts a key load
    put_byte(8'h7F);
    in_valid = 1'b0;
    chk_eq("bad_cmd_idle", 128'(busy), 128'(0));
    put_byte(8'h01);
    in_valid = 1'b0;
    chk_eq("key_after_bad", 128'(busy), 128'(1));
    for (int i = 0; i < 16; i++) put_byte(KEY_C1[127-8*i -: 8]);
    in_valid = 1'b0;
    chk_eq("key_reload", key_out, KEY_C1);

    // Run with a non-vector plaintext, then reset part-way through TX
    send_block(8'h02, 128'hdeadbeef_01234567_89abcdef_f00dcafe);
    @(posedge clk); #1;
    push_expect(core_f(KEY_C1, 128'hdeadbeef_01234567_89abcdef_f00dcafe));
    put_byte(8'h03);
    in_valid = 1'b0;
    wait_out_valid("abort_tx_start");
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk_eq("abort_tx_vld",  128'(out_valid), 128'(0));
    chk_eq("abort_tx_busy", 128'(busy), 128'(0));
    chk_eq("abort_tx_data", 128'(out_data), 128'(0));
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_byte_loader.md
AES_BYTE_LOADER -- requirements
Module: aes_byte_loader

Interface
REQ-001 Parameter AES_LATENCY, default 21, meaning clock cycles from stable state_out/key_out to valid ct_in; legal range 1..255.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset rst, synchronous, active-high.
REQ-004 in_valid  input  1  host byte valid.
REQ-005 in_ready  output  1  loader accepts byte; transfer when in_valid && in_ready.
REQ-006 in_data  input  8  host command/payload byte.
REQ-007 key_out  output  128  key to the AES core.
REQ-008 state_out  output  128  plaintext to the AES core.
REQ-009 load_strobe  output  1  one-cycle pulse after key_out or state_out changes.
REQ-010 ct_in  input  128  ciphertext from the AES core.
REQ-011 out_valid  output  1  result byte valid.
REQ-012 out_ready  input  1  host accepts byte; transfer when out_valid && out_ready.
REQ-013 out_data  output  8  result byte.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, RX_KEY, RX_STATE, WAIT, TX.
REQ-016 IDLE, accepted byte: 0x01 -> RX_KEY; 0x02 -> RX_STATE; 0x03 -> WAIT with counter = AES_LATENCY; any other value dropped, stay IDLE.
REQ-017 in_ready SHALL be 1 in IDLE, RX_KEY, RX_STATE and 0 in WAIT, TX.
REQ-018 RX_KEY/RX_STATE: each accepted byte shifts into a 128-bit shadow register from the LSB end; the first byte ends in bits [127:120].
REQ-019 A 4-bit byte counter SHALL track payload bytes; on the 16th accepted byte the full value (shadow plus that byte) commits to key_out or state_out in the same edge; FSM -> IDLE.
REQ-020 key_out/state_out SHALL hold their value during partial loads; a partial load never alters them.
REQ-021 load_strobe SHALL be high for exactly the one cycle after a commit edge.
REQ-022 WAIT: counter decrements once per cycle; when the counter equals 1, the next edge captures ct_in into the TX shift register and moves to TX, so ct_in is sampled AES_LATENCY cycles after entering WAIT.
REQ-023 TX: out_valid = 1, out_data = shift[127:120]; on each transfer shift left 8 bits; after the 16th transfer -> IDLE, out_valid = 0.
REQ-024 out_data SHALL stay stable while out_valid && !out_ready.
REQ-025 in_valid asserted while in_ready = 0 SHALL be ignored; no byte is lost or queued.
REQ-026 Back-to-back transfers every cycle SHALL be sustained on both byte interfaces.

Reset
REQ-027 rst SHALL force IDLE and set key_out = 0, state_out = 0, shadow = 0, counters = 0, load_strobe = 0, out_valid = 0, busy = 0, out_data = 0.
REQ-028 rst asserted mid-load, in WAIT or in TX SHALL abort the operation; the partial payload is discarded and no commit or strobe occurs.

Configuration
REQ-029 With AES_BYTE_LOADER_CHK_EN defined, TX SHALL send a 17th byte equal to the XOR of the 16 ciphertext bytes before returning to IDLE.
REQ-030 Without AES_BYTE_LOADER_CHK_EN, TX SHALL send exactly 16 bytes and the checksum logic SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the command codes CMD_KEY = 0x01, CMD_STATE = 0x02 and CMD_RUN = 0x03, and the block width of 128 bits.
REQ-032 One sub-module, aes_byte_shifter, SHALL implement the 128-bit byte shift register with load, shift and parallel output, instantiated once for RX and once for TX.

Verification
REQ-033 Scenario 1: send 0x01 followed by bytes 00..0F -> key_out = 000102030405060708090a0b0c0d0e0f and load_strobe pulses once.
REQ-034 Scenario 2: with the scenario 1 key, send 0x02 followed by 00112233445566778899aabbccddeeff, then 0x03, using the real aes_128 core -> out bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
REQ-035 Scenario 3: hold out_ready = 0 for 5 cycles during TX -> out_data stays at the same byte and no byte is skipped.
REQ-036 Scenario 4: send 0x02 followed by 7 bytes, then pulse rst -> state_out = 0, no load_strobe, FSM in IDLE.
REQ-037 Scenario 5: send 0x7F, then 0x01 -> 0x7F is dropped and the next byte enters RX_KEY; in_valid during WAIT is ignored.
REQ-038 Scenario 6: with AES_BYTE_LOADER_CHK_EN defined, repeat scenario 2 -> a 17th byte equal to the XOR of the 16 ciphertext bytes is sent.
